// File: rtl/exception_unit.sv
// Machine-mode exception unit: trap entry and MRET return, the five M-mode CSRs,
// and the pipeline flush/redirect controls that go with them.
// A trap takes two cycles. The detect cycle saves mepc, mcause and mstatus and
// flushes the front of the pipe. The TRAP2 cycle writes mtval and steers fetch to mtvec.
module exception_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_ms,
    input  logic [2:0]  exp_vector_ms,
    input  logic        mret_ms,
    input  logic        interrupt,
    input  logic [31:0] epc_cur,
    input  logic [31:0] epc_next,
    input  logic [31:0] inst_ms,
    input  logic        csr_rw_ms,
    input  logic        csr_w_imm_mux,
    input  logic [1:0]  csr_wsc_mode,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_rs1,
    input  logic [4:0]  csr_zimm,
    output logic [31:0] csr_rdata,
    output logic        redirect_mux,
    output logic [31:0] PC_redirect,
    output logic        reg_FD_flush,
    output logic        reg_DE_flush,
    output logic        reg_EM_flush,
    output logic        reg_MW_flush
);

    typedef enum logic {IDLE = 1'b0, TRAP2 = 1'b1} state_t;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_IRQ     = 32'h8000_000B;

    state_t      state_q, state_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    // Faulting instruction word held from the detect cycle until TRAP2 writes mtval.
    logic [31:0] tval_hold_q, tval_hold_d;

    logic        is_idle;
    logic        exc_ebreak, exc_illegal, exc_ecall;
    logic        exception, irq_take, trap, mret_take, csr_we;
    logic [31:0] trap_cause;
    logic [31:0] csr_operand, csr_wdata;

    assign is_idle     = (state_q == IDLE);
    assign exc_ebreak  = exp_vector_ms[2];
    assign exc_illegal = exp_vector_ms[1];
    assign exc_ecall   = exp_vector_ms[0];
    assign exception   = valid_ms & (|exp_vector_ms);
    assign irq_take    = valid_ms & interrupt & mie_q & ~exception & ~mret_ms;
    assign trap        = is_idle & (exception | irq_take);
    assign mret_take   = is_idle & valid_ms & mret_ms & ~exception;
    assign csr_we      = is_idle & valid_ms & csr_rw_ms & ~trap & (csr_wsc_mode != 2'b00);
    assign csr_operand = csr_w_imm_mux ? {27'b0, csr_zimm} : csr_rs1;

    // Cause encoding; illegal outranks ECALL, which outranks EBREAK.
    always_comb begin
        trap_cause = CAUSE_IRQ;
        if (exception) begin
            if (exc_illegal)     trap_cause = CAUSE_ILLEGAL;
            else if (exc_ecall)  trap_cause = CAUSE_ECALL;
            else                 trap_cause = CAUSE_EBREAK;
        end
    end

    // CSR read port returns the value before this cycle's update.
    always_comb begin
        case (csr_addr)
            ADDR_MSTATUS: csr_rdata = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
            ADDR_MTVEC:   csr_rdata = mtvec_q;
            ADDR_MEPC:    csr_rdata = mepc_q;
            ADDR_MCAUSE:  csr_rdata = mcause_q;
            ADDR_MTVAL:   csr_rdata = mtval_q;
            default:      csr_rdata = 32'b0;
        endcase
    end

    // Software write value for write / set / clear.
    always_comb begin
        case (csr_wsc_mode)
            2'b01:   csr_wdata = csr_operand;
            2'b10:   csr_wdata = csr_rdata | csr_operand;
            2'b11:   csr_wdata = csr_rdata & ~csr_operand;
            default: csr_wdata = csr_rdata;
        endcase
    end

    // Next CSR and FSM state. Trap and MRET updates come after the software write so they take precedence.
    always_comb begin
        mie_d       = mie_q;
        mpie_d      = mpie_q;
        mtvec_d     = mtvec_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mtval_d     = mtval_q;
        tval_hold_d = tval_hold_q;

        if (csr_we) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mie_d  = csr_wdata[3];
                    mpie_d = csr_wdata[7];
                end
                ADDR_MTVEC:  mtvec_d  = csr_wdata;
                ADDR_MEPC:   mepc_d   = csr_wdata;
                ADDR_MCAUSE: mcause_d = csr_wdata;
                ADDR_MTVAL:  mtval_d  = csr_wdata;
                default: ;
            endcase
        end

        if (trap) begin
            mepc_d      = exception ? epc_cur : epc_next;
            mcause_d    = trap_cause;
            mpie_d      = mie_q;
            mie_d       = 1'b0;
            tval_hold_d = (exception & exc_illegal) ? inst_ms : 32'b0;
        end

        if (mret_take) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end

        if (state_q == TRAP2) begin
            mtval_d = tval_hold_q;
        end

        state_d = trap ? TRAP2 : IDLE;
    end

    // Redirect and flush controls. They are decoded from the state and this cycle's inputs, and reset masks them at once.
    always_comb begin
        redirect_mux = 1'b0;
        PC_redirect  = 32'b0;
        reg_FD_flush = 1'b0;
        reg_DE_flush = 1'b0;
        reg_EM_flush = 1'b0;
        reg_MW_flush = 1'b0;
        if (!rst) begin
            if (state_q == TRAP2) begin
                redirect_mux = 1'b1;
                PC_redirect  = mtvec_q;
                reg_FD_flush = 1'b1;
            end else if (trap) begin
                reg_FD_flush = 1'b1;
                reg_DE_flush = 1'b1;
                reg_EM_flush = 1'b1;
                reg_MW_flush = exception;
            end else if (mret_take) begin
                redirect_mux = 1'b1;
                PC_redirect  = mepc_q;
                reg_FD_flush = 1'b1;
                reg_DE_flush = 1'b1;
                reg_EM_flush = 1'b1;
            end
        end
    end

    // State and CSR registers. Asynchronous reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            mtvec_q     <= 32'b0;
            mepc_q      <= 32'b0;
            mcause_q    <= 32'b0;
            mtval_q     <= 32'b0;
            tval_hold_q <= 32'b0;
        end else begin
            state_q     <= state_d;
            mie_q       <= mie_d;
            mpie_q      <= mpie_d;
            mtvec_q     <= mtvec_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            tval_hold_q <= tval_hold_d;
        end
    end

endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit. Each step drives the inputs and queues
// the expected outputs. The queue is drained against the DUT mid-cycle, away from the clock edge.
module tb_exception_unit;

    localparam int O_RDATA = 0;
    localparam int O_REDIR = 1;
    localparam int O_PC    = 2;
    localparam int O_FLUSH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_ms, mret_ms, interrupt, csr_rw_ms, csr_w_imm_mux;
    logic [2:0]  exp_vector_ms;
    logic [31:0] epc_cur, epc_next, inst_ms, csr_rs1;
    logic [1:0]  csr_wsc_mode;
    logic [11:0] csr_addr;
    logic [4:0]  csr_zimm;
    logic [31:0] csr_rdata, PC_redirect;
    logic        redirect_mux, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    exception_unit dut (
        .clk(clk), .rst(rst), .valid_ms(valid_ms), .exp_vector_ms(exp_vector_ms),
        .mret_ms(mret_ms), .interrupt(interrupt), .epc_cur(epc_cur), .epc_next(epc_next),
        .inst_ms(inst_ms), .csr_rw_ms(csr_rw_ms), .csr_w_imm_mux(csr_w_imm_mux),
        .csr_wsc_mode(csr_wsc_mode), .csr_addr(csr_addr), .csr_rs1(csr_rs1),
        .csr_zimm(csr_zimm), .csr_rdata(csr_rdata), .redirect_mux(redirect_mux),
        .PC_redirect(PC_redirect), .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
        .reg_EM_flush(reg_EM_flush), .reg_MW_flush(reg_MW_flush)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            O_RDATA: return csr_rdata;
            O_REDIR: return {31'b0, redirect_mux};
            O_PC:    return PC_redirect;
            default: return {28'b0, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // Called just after a falling edge: settle, compare, then advance one full clock.
    task automatic cycle();
        #2;
        drain();
        @(negedge clk);
    endtask

    task automatic clr();
        valid_ms = 0; exp_vector_ms = 0; mret_ms = 0; interrupt = 0;
        epc_cur = 0; epc_next = 0; inst_ms = 0; csr_rw_ms = 0; csr_w_imm_mux = 0;
        csr_wsc_mode = 0; csr_addr = 0; csr_rs1 = 0; csr_zimm = 0;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        clr();
        csr_addr = addr;
        push(tag, O_RDATA, exp);
        push({tag, "_quiet"}, O_FLUSH, 32'h0);
        cycle();
    endtask

    task automatic csr_op(input logic [11:0] addr, input logic [1:0] mode, input logic imm,
                          input logic [31:0] val);
        clr();
        valid_ms = 1; csr_rw_ms = 1; csr_addr = addr; csr_wsc_mode = mode;
        csr_w_imm_mux = imm; csr_rs1 = val; csr_zimm = val[4:0];
        push("csr_op_flush", O_FLUSH, 32'h0);
        push("csr_op_redir", O_REDIR, 32'h0);
        cycle();
    endtask

    // TRAP2 cycle with a competing ECALL and MRET that must both be ignored.
    task automatic trap2(input string tag);
        clr();
        valid_ms = 1; exp_vector_ms = 3'b001; mret_ms = 1;
        push({tag, "_t2_redir"}, O_REDIR, 32'h1);
        push({tag, "_t2_pc"},    O_PC,    32'h100);
        push({tag, "_t2_flush"}, O_FLUSH, 32'h8);
        cycle();
    endtask

    logic [2:0]  pv_vec  [3] = '{3'b111, 3'b101, 3'b100};
    logic [31:0] pv_cause[3] = '{32'd2, 32'd11, 32'd3};
    logic [31:0] pv_tval [3] = '{32'h1234_5678, 32'h0, 32'h0};

    initial begin
        clr();
        rst = 1;
        @(negedge clk);
        // Reset holds outputs low even with an exception presented.
        valid_ms = 1; exp_vector_ms = 3'b010; csr_addr = 12'h305;
        push("rst_flush", O_FLUSH, 32'h0);
        push("rst_redir", O_REDIR, 32'h0);
        push("rst_mtvec", O_RDATA, 32'h0);
        cycle();
        rst = 0;
        rd("reset_mstatus", 12'h300, 32'h0);
        rd("reset_mepc",    12'h341, 32'h0);

        // Illegal-instruction trap at 0x40 vectoring to 0x100.
        clr();
        valid_ms = 1; csr_rw_ms = 1; csr_wsc_mode = 2'b01; csr_addr = 12'h305; csr_rs1 = 32'h100;
        push("csrrw_pre", O_RDATA, 32'h0);
        cycle();
        rd("mtvec", 12'h305, 32'h100);
        clr();
        valid_ms = 1; exp_vector_ms = 3'b010; epc_cur = 32'h40; epc_next = 32'h44;
        inst_ms = 32'hFFFF_FFFF;
        push("ill_flush", O_FLUSH, 32'hF);
        push("ill_redir", O_REDIR, 32'h0);
        cycle();
        trap2("ill");
        rd("ill_mepc",    12'h341, 32'h40);
        rd("ill_mcause",  12'h342, 32'h2);
        rd("ill_mtval",   12'h343, 32'hFFFF_FFFF);
        rd("ill_mstatus", 12'h300, 32'h0);

        // Set/clear of MIE and an unimplemented address.
        csr_op(12'h300, 2'b10, 1'b1, 32'h8);
        rd("csrrsi_mstatus", 12'h300, 32'h8);
        csr_op(12'h300, 2'b11, 1'b0, 32'h8);
        rd("csrrc_mstatus", 12'h300, 32'h0);
        csr_op(12'h7C0, 2'b01, 1'b0, 32'hDEAD_BEEF);
        rd("unimpl_7c0", 12'h7C0, 32'h0);

        // Exception priority when several decode bits are set.
        for (int i = 0; i < 3; i++) begin
            clr();
            valid_ms = 1; exp_vector_ms = pv_vec[i]; epc_cur = 32'h80; inst_ms = 32'h1234_5678;
            push("prio_flush", O_FLUSH, 32'hF);
            cycle();
            trap2("prio");
            rd("prio_mcause", 12'h342, pv_cause[i]);
            rd("prio_mtval",  12'h343, pv_tval[i]);
        end

        // Interrupt without valid, then with MIE clear: neither traps.
        csr_op(12'h300, 2'b10, 1'b1, 32'h8);
        clr();
        interrupt = 1; epc_next = 32'h24;
        push("irq_novalid_flush", O_FLUSH, 32'h0);
        push("irq_novalid_redir", O_REDIR, 32'h0);
        cycle();
        csr_op(12'h300, 2'b11, 1'b1, 32'h8);
        clr();
        valid_ms = 1; interrupt = 1; epc_next = 32'h24;
        push("irq_mie0_flush", O_FLUSH, 32'h0);
        push("irq_mie0_redir", O_REDIR, 32'h0);
        cycle();
        rd("irq_none_mcause", 12'h342, 32'h3);

        // Interrupt taken; the interrupted instruction still retires.
        csr_op(12'h300, 2'b10, 1'b1, 32'h8);
        clr();
        valid_ms = 1; interrupt = 1; epc_cur = 32'h20; epc_next = 32'h24;
        push("irq_flush", O_FLUSH, 32'hE);
        cycle();
        trap2("irq");
        rd("irq_mcause",  12'h342, 32'h8000_000B);
        rd("irq_mepc",    12'h341, 32'h24);
        rd("irq_mstatus", 12'h300, 32'h80);
        rd("irq_mtval",   12'h343, 32'h0);

        // ECALL wins over interrupt; MRET then restores MIE.
        csr_op(12'h300, 2'b10, 1'b1, 32'h8);
        rd("pre_ecall_mstatus", 12'h300, 32'h88);
        clr();
        valid_ms = 1; exp_vector_ms = 3'b001; interrupt = 1; epc_cur = 32'h60; epc_next = 32'h64;
        push("ecall_flush", O_FLUSH, 32'hF);
        cycle();
        trap2("ecall");
        rd("ecall_mcause",  12'h342, 32'd11);
        rd("ecall_mepc",    12'h341, 32'h60);
        rd("ecall_mstatus", 12'h300, 32'h80);
        clr();
        valid_ms = 1; mret_ms = 1;
        push("mret_redir", O_REDIR, 32'h1);
        push("mret_pc",    O_PC,    32'h60);
        push("mret_flush", O_FLUSH, 32'hE);
        cycle();
        rd("mret_mstatus", 12'h300, 32'h88);

        // A trap drops a same-cycle software write to mepc.
        clr();
        valid_ms = 1; exp_vector_ms = 3'b001; epc_cur = 32'h70;
        csr_rw_ms = 1; csr_wsc_mode = 2'b01; csr_addr = 12'h341; csr_rs1 = 32'h999;
        push("ovr_flush", O_FLUSH, 32'hF);
        cycle();
        trap2("ovr");
        rd("ovr_mepc",  12'h341, 32'h70);
        rd("ovr_mtvec", 12'h305, 32'h100);

        // MRET beats a pending interrupt and does not start a trap.
        csr_op(12'h300, 2'b10, 1'b1, 32'h8);
        clr();
        valid_ms = 1; mret_ms = 1; interrupt = 1; epc_next = 32'h74;
        push("mret_irq_redir", O_REDIR, 32'h1);
        push("mret_irq_pc",    O_PC,    32'h70);
        push("mret_irq_flush", O_FLUSH, 32'hE);
        cycle();
        clr();
        push("after_mret_redir", O_REDIR, 32'h0);
        push("after_mret_flush", O_FLUSH, 32'h0);
        cycle();
        rd("mret_irq_mcause",  12'h342, 32'd11);
        rd("mret_irq_mstatus", 12'h300, 32'h88);

        // Reset asserted between clock edges during TRAP2 aborts the redirect.
        clr();
        valid_ms = 1; exp_vector_ms = 3'b010; epc_cur = 32'h90;
        push("pre_rst_flush", O_FLUSH, 32'hF);
        cycle();
        clr();
        csr_addr = 12'h305;
        #2;
        push("t2_before_rst", O_REDIR, 32'h1);
        drain();
        #1 rst = 1;
        #1;
        push("rst_async_redir", O_REDIR, 32'h0);
        push("rst_async_pc",    O_PC,    32'h0);
        push("rst_async_flush", O_FLUSH, 32'h0);
        push("rst_async_mtvec", O_RDATA, 32'h0);
        drain();
        @(negedge clk);
        rst = 0;
        rd("post_rst_mepc",    12'h341, 32'h0);
        rd("post_rst_mstatus", 12'h300, 32'h0);
        clr();
        push("post_rst_redir", O_REDIR, 32'h0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
